// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_AW            register address width
//   FWD_RF/WB/MEM     EX operand forwarding select encodings
//   state_e           hazard sequencer states (RUN, FLUSH, MEM_WAIT)
package pipe_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MEM_WAIT = 2'b10
    } state_e;

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding compare for one EX source operand.
//   ex_src                     source register read by the EX instruction
//   mem_rd / mem_reg_write     destination and write flag in EX_MEM
//   wb_rd  / wb_reg_write      destination and write flag in MEM_WB
//   fwd_sel                    FWD_MEM, FWD_WB or FWD_RF
module fwd_unit #(
    parameter int AW = pipe_pkg::REG_AW
) (
    input  logic [AW-1:0] ex_src,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_reg_write,
    output logic [1:0]    fwd_sel
);
    import pipe_pkg::*;

    // MEM is the younger producer so it wins over WB; r0 is hard-wired and never forwarded.
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_reg_write && (mem_rd != {AW{1'b0}}) && (mem_rd == ex_src)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != {AW{1'b0}}) && (wb_rd == ex_src)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for a 5-stage pipeline.
// Inputs : ID/EX/MEM/WB register fields and write flags, ex_mem_read,
//          ex_branch_taken, dmem_busy.
// Outputs: hold/clear for PC, IF_ID, ID_EX, EX_MEM (combinational, same
//          cycle as the hazard), fwd_a/fwd_b operand selects, and
//          saturating stall_cnt / flush_cnt event counters.
// Priority within a cycle: dmem_busy, then taken branch, then load-use.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = pipe_pkg::REG_AW,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              dmem_busy,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_id_clear,
    output logic              id_ex_hold,
    output logic              id_ex_clear,
    output logic              ex_mem_hold,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    import pipe_pkg::*;

    localparam int FC_W = 2;  // holds FLUSH_CYC-1 for FLUSH_CYC in 1..3
    localparam logic [FC_W-1:0]  FC_ONE  = {{(FC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    state_e            resume_q, resume_d;
    state_e            eff_state_s;
    logic [FC_W-1:0]   flush_rem_q, flush_rem_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use_s;
    logic flush_evt_s;
    logic pc_hold_s, if_id_hold_s, if_id_clear_s;
    logic id_ex_hold_s, id_ex_clear_s, ex_mem_hold_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    // Loads are recognised by ex_mem_read alone; the write flag is not needed here.
    logic unused_ex_reg_write_s;
    assign unused_ex_reg_write_s = ex_reg_write;

    assign load_use_s = ex_mem_read && (ex_rd != {REG_AW{1'b0}}) &&
                        ((id_use_rs && (id_rs == ex_rd)) ||
                         (id_use_rt && (id_rt == ex_rd)));

    // While waiting on memory we act as the interrupted state the moment busy drops.
    assign eff_state_s = (state_q == MEM_WAIT) ? resume_q : state_q;

    // Hazard sequencing: next state, flush down-count and hold/clear strobes.
    always_comb begin
        state_d       = state_q;
        resume_d      = resume_q;
        flush_rem_d   = flush_rem_q;
        flush_evt_s   = 1'b0;
        pc_hold_s     = 1'b0;
        if_id_hold_s  = 1'b0;
        if_id_clear_s = 1'b0;
        id_ex_hold_s  = 1'b0;
        id_ex_clear_s = 1'b0;
        ex_mem_hold_s = 1'b0;
        if (dmem_busy) begin
            // Freeze the whole front of the pipe; flush progress is parked untouched.
            pc_hold_s     = 1'b1;
            if_id_hold_s  = 1'b1;
            id_ex_hold_s  = 1'b1;
            ex_mem_hold_s = 1'b1;
            state_d       = MEM_WAIT;
            resume_d      = eff_state_s;
        end else begin
            resume_d = RUN;
            case (eff_state_s)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_clear_s = 1'b1;
                        id_ex_clear_s = 1'b1;
                        flush_evt_s   = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            state_d     = FLUSH;
                            flush_rem_d = FC_W'(FLUSH_CYC - 1);
                        end else begin
                            state_d     = RUN;
                            flush_rem_d = {FC_W{1'b0}};
                        end
                    end else if (load_use_s) begin
                        // One bubble: the load moves to MEM next cycle, clearing the condition.
                        pc_hold_s     = 1'b1;
                        if_id_hold_s  = 1'b1;
                        id_ex_clear_s = 1'b1;
                        state_d       = RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    // Branches raised here come from squashed instructions and are ignored.
                    if_id_clear_s = 1'b1;
                    id_ex_clear_s = 1'b1;
                    if (flush_rem_q <= FC_ONE) begin
                        flush_rem_d = {FC_W{1'b0}};
                        state_d     = RUN;
                    end else begin
                        flush_rem_d = flush_rem_q - FC_ONE;
                        state_d     = FLUSH;
                    end
                end
                default: begin
                    flush_rem_d = {FC_W{1'b0}};
                    state_d     = RUN;
                end
            endcase
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_hold_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_evt_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Sequencer state, pending flush count and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            resume_q    <= RUN;
            flush_rem_q <= {FC_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            flush_rem_q <= flush_rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .ex_src        (ex_rs),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (fwd_a_s)
    );

    fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .ex_src        (ex_rt),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (fwd_b_s)
    );

    // Strobes are combinational, so they are forced low while reset is held.
    assign pc_hold     = rst_n & pc_hold_s;
    assign if_id_hold  = rst_n & if_id_hold_s;
    assign if_id_clear = rst_n & if_id_clear_s;
    assign id_ex_hold  = rst_n & id_ex_hold_s;
    assign id_ex_clear = rst_n & id_ex_clear_s;
    assign ex_mem_hold = rst_n & ex_mem_hold_s;
    assign fwd_a       = rst_n ? fwd_a_s : FWD_RF;
    assign fwd_b       = rst_n ? fwd_b_s : FWD_RF;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int AW = 5;
    localparam int FC = 2;
    localparam int CW = 16;

    localparam logic [5:0] HZ_NONE = 6'b000000;
    localparam logic [5:0] HZ_HOLD = 6'b110101;  // pc, if_id, id_ex, ex_mem holds
    localparam logic [5:0] HZ_CLR  = 6'b001010;  // if_id and id_ex clears
    localparam logic [5:0] HZ_LU   = 6'b110010;  // pc hold, if_id hold, id_ex clear

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_use_rs, id_use_rt, ex_reg_write, ex_mem_read, ex_branch_taken;
    logic mem_reg_write, wb_reg_write, dmem_busy;
    logic pc_hold, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear, ex_mem_hold;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [5:0] hz;

    int n_chk = 0;
    int n_pass = 0;

    assign hz = {pc_hold, if_id_hold, if_id_clear, id_ex_hold, id_ex_clear, ex_mem_hold};

    pipe_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYC(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_busy(dmem_busy),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_clear(if_id_clear),
        .id_ex_hold(id_ex_hold), .id_ex_clear(id_ex_clear), .ex_mem_hold(ex_mem_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reference forwarding rule: newest writer wins, r0 never forwarded.
    function automatic logic [1:0] ref_fwd(input int src, input int mrd, input bit mw,
                                           input int wrd, input bit ww);
        if (mw && mrd != 0 && mrd == src) return 2'b10;
        if (ww && wrd != 0 && wrd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        dmem_busy = 1'b1; ex_branch_taken = 1'b1;
        mem_rd = 5'd3; ex_rs = 5'd3; mem_reg_write = 1'b1;
        @(negedge clk);
        n_chk++; if (hz !== HZ_NONE) $display("FAIL reset_hz: got %b want %b", hz, HZ_NONE); else n_pass++;
        n_chk++; if (fwd_a !== 2'b00) $display("FAIL reset_fwd_a: got %b want 00", fwd_a); else n_pass++;
        n_chk++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        tick();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (hz !== HZ_NONE) $display("FAIL post_reset_hz: got %b want %b", hz, HZ_NONE); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd2; id_rs = 5'd2; id_use_rs = 1'b1;
        @(negedge clk);
        n_chk++; if (hz !== HZ_LU) $display("FAIL load_use_hz: got %b want %b", hz, HZ_LU); else n_pass++;
        n_chk++; if (stall_cnt !== 16'd0) $display("FAIL load_use_cnt0: got %0d want 0", stall_cnt); else n_pass++;
        tick();
        // Load has advanced to MEM.
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd3; ex_rs = 5'd2;
        mem_rd = 5'd2; mem_reg_write = 1'b1;
        @(negedge clk);
        n_chk++; if (hz !== HZ_NONE) $display("FAIL load_use_next_hz: got %b want %b", hz, HZ_NONE); else n_pass++;
        n_chk++; if (stall_cnt !== 16'd1) $display("FAIL load_use_cnt1: got %0d want 1", stall_cnt); else n_pass++;
        n_chk++; if (fwd_a !== 2'b10) $display("FAIL load_use_fwd: got %b want 10", fwd_a); else n_pass++;
        tick();
        // rt match with rs unused.
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1; id_rs = 5'd7;
        @(negedge clk);
        n_chk++; if (hz !== HZ_LU) $display("FAIL load_use_rt_hz: got %b want %b", hz, HZ_LU); else n_pass++;
        tick();
        id_use_rt = 1'b0;
        @(negedge clk);
        n_chk++; if (hz !== HZ_NONE) $display("FAIL load_use_unused_hz: got %b want %b", hz, HZ_NONE); else n_pass++;
        tick();
    endtask

    task automatic test_load_use_r0();
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        @(negedge clk);
        n_chk++; if (hz !== HZ_NONE) $display("FAIL r0_hz: got %b want %b", hz, HZ_NONE); else n_pass++;
        tick();
        idle();
        @(negedge clk);
        n_chk++; if (stall_cnt !== 16'd0) $display("FAIL r0_cnt: got %0d want 0", stall_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_branch_flush();
        do_reset();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        n_chk++; if (hz !== HZ_CLR) $display("FAIL br_c1_hz: got %b want %b", hz, HZ_CLR); else n_pass++;
        tick();
        // Second taken branch comes from a squashed instruction.
        @(negedge clk);
        n_chk++; if (hz !== HZ_CLR) $display("FAIL br_c2_hz: got %b want %b", hz, HZ_CLR); else n_pass++;
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        n_chk++; if (hz !== HZ_NONE) $display("FAIL br_c3_hz: got %b want %b", hz, HZ_NONE); else n_pass++;
        n_chk++; if (flush_cnt !== 16'd1) $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait_in_flush();
        do_reset();
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (hz !== HZ_HOLD) $display("FAIL mw_hold%0d_hz: got %b want %b", i, hz, HZ_HOLD); else n_pass++;
            tick();
        end
        dmem_busy = 1'b0;
        @(negedge clk);
        n_chk++; if (hz !== HZ_CLR) $display("FAIL mw_resume_hz: got %b want %b", hz, HZ_CLR); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (hz !== HZ_NONE) $display("FAIL mw_run_hz: got %b want %b", hz, HZ_NONE); else n_pass++;
        n_chk++; if (stall_cnt !== 16'd3 || flush_cnt !== 16'd1)
            $display("FAIL mw_cnt: got %0d/%0d want 3/1", stall_cnt, flush_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_forwarding();
        idle();
        ex_rs = 5'd5; mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        @(negedge clk);
        n_chk++; if (fwd_a !== 2'b10) $display("FAIL fwd_mem: got %b want 10", fwd_a); else n_pass++;
        mem_reg_write = 1'b0;
        @(posedge clk); @(negedge clk);
        n_chk++; if (fwd_a !== 2'b01) $display("FAIL fwd_wb: got %b want 01", fwd_a); else n_pass++;
        ex_rt = 5'd0; wb_rd = 5'd0; mem_rd = 5'd0; mem_reg_write = 1'b1;
        @(posedge clk); @(negedge clk);
        n_chk++; if (fwd_b !== 2'b00) $display("FAIL fwd_r0: got %b want 00", fwd_b); else n_pass++;
        ex_rt = 5'd9; mem_rd = 5'd4; wb_rd = 5'd9;
        @(posedge clk); @(negedge clk);
        n_chk++; if (fwd_b !== 2'b01) $display("FAIL fwd_b_wb: got %b want 01", fwd_b); else n_pass++;
        tick();
        idle();
    endtask

    task automatic test_random();
        int m_left, m_stall, m_flush;
        logic [5:0] e_hz;
        logic [1:0] e_a, e_b;
        bit lu;
        do_reset();
        m_left = 0; m_stall = 0; m_flush = 0;
        for (int c = 0; c < 500; c++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1)); id_use_rt = 1'($urandom_range(0, 1));
            ex_reg_write = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
            mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            dmem_busy = ($urandom_range(0, 5) == 0);
            lu = ex_mem_read && ex_rd != 0 &&
                 ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
            e_a = ref_fwd(int'(ex_rs), int'(mem_rd), mem_reg_write, int'(wb_rd), wb_reg_write);
            e_b = ref_fwd(int'(ex_rt), int'(mem_rd), mem_reg_write, int'(wb_rd), wb_reg_write);
            @(negedge clk);
            if (dmem_busy) e_hz = HZ_HOLD;
            else if (m_left > 0) e_hz = HZ_CLR;
            else if (ex_branch_taken) e_hz = HZ_CLR;
            else if (lu) e_hz = HZ_LU;
            else e_hz = HZ_NONE;
            n_chk++; if (hz !== e_hz) $display("FAIL rnd_hz c%0d: got %b want %b", c, hz, e_hz); else n_pass++;
            n_chk++; if (fwd_a !== e_a || fwd_b !== e_b)
                $display("FAIL rnd_fwd c%0d: got %b/%b want %b/%b", c, fwd_a, fwd_b, e_a, e_b); else n_pass++;
            n_chk++; if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush))
                $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, m_stall, m_flush);
            else n_pass++;
            // Advance the model by one cycle.
            if (dmem_busy) m_stall++;
            else if (m_left > 0) m_left--;
            else if (ex_branch_taken) begin m_flush++; m_left = FC - 1; end
            else if (lu) m_stall++;
            tick();
        end
        idle();
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        dmem_busy = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        @(negedge clk);
        n_chk++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_sat: got %h want ffff", stall_cnt); else n_pass++;
        tick();
        dmem_busy = 1'b0; ex_branch_taken = 1'b1;
        @(negedge clk);
        n_chk++; if (hz !== HZ_CLR) $display("FAIL sat_br_hz: got %b want %b", hz, HZ_CLR); else n_pass++;
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        n_chk++; if (hz !== HZ_CLR || flush_cnt !== 16'd1)
            $display("FAIL sat_flush: got %b/%0d want %b/1", hz, flush_cnt, HZ_CLR); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (hz !== HZ_NONE) $display("FAIL midrst_hz: got %b want %b", hz, HZ_NONE); else n_pass++;
        n_chk++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL midrst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++; if (hz !== HZ_NONE) $display("FAIL postrst%0d_hz: got %b want %b", i, hz, HZ_NONE); else n_pass++;
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_load_use_r0();
        test_branch_flush();
        test_mem_wait_in_flush();
        test_forwarding();
        test_random();
        test_saturation_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
